// File: rtl/alu.sv
// Single-cycle registered 8-bit ALU: eight operations selected by a 3-bit code,
// result and zero flag both captured on the rising clock edge.
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [2:0] operation,
  output logic [7:0] result,
  output logic       zero
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  logic [7:0]        result_q, result_d;
  logic              zero_q, zero_d;

  logic [3:0]        shamt;
  logic [2:0]        rot;
  logic [7:0]        sll_v;
  logic [7:0]        sra_v;
  logic signed [7:0] sra_s;
  logic [7:0]        ror_v;

  assign shamt = data2[3:0];
  assign rot   = data2[2:0];

  // Shifts by 8..15 saturate to all-zero / all-sign.
  always_comb begin
    sll_v = shamt[3] ? 8'h00 : (data1 << shamt[2:0]);
    sra_s = $signed(data1) >>> shamt[2:0];
    sra_v = shamt[3] ? {8{data1[7]}} : sra_s;
    ror_v = (data1 >> rot) | (data1 << (4'd8 - {1'b0, rot}));
  end

  always_comb begin
    result_d = 8'h00;
    unique case (operation)
      OP_FWD:  result_d = data2;
      OP_ADD:  result_d = data1 + data2;
      OP_AND:  result_d = data1 & data2;
      OP_OR:   result_d = data1 | data2;
      OP_MUL:  result_d = data1 * data2;
      OP_SLL:  result_d = sll_v;
      OP_SRA:  result_d = sra_v;
      OP_ROR:  result_d = ror_v;
      default: result_d = 8'h00;
    endcase
    zero_d = (result_d == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 8'h00;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
// Each step applies inputs, waits one rising edge, then checks result/zero.
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] operation;
  logic [7:0] result;
  logic       zero;

  int compared;
  int mismatched;

  alu dut (
    .clk       (clk),
    .reset     (reset),
    .data1     (data1),
    .data2     (data2),
    .operation (operation),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] er,
                     input logic ez);
    compared++;
    assert (result === er) else begin
      mismatched++;
      $error("FAIL %s result=%h expected %h", tag, result, er);
    end
    compared++;
    assert (zero === ez) else begin
      mismatched++;
      $error("FAIL %s zero=%b expected %b", tag, zero, ez);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    reset     = rst;
    operation = op;
    data1     = a;
    data2     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    operation  = 3'b000;
    data1      = 8'h00;
    data2      = 8'h00;
    #2;

    step(1'b1, 3'b001, 8'd3, 8'd4);
    chk("reset", 8'h00, 1'b1);

    step(1'b0, 3'b000, 8'd3, 8'd4);
    chk("fwd", 8'd4, 1'b0);
    step(1'b0, 3'b001, 8'd3, 8'd4);
    chk("add", 8'd7, 1'b0);
    step(1'b0, 3'b010, 8'd3, 8'd4);
    chk("and", 8'd0, 1'b1);
    step(1'b0, 3'b011, 8'd3, 8'd4);
    chk("or", 8'd7, 1'b0);

    step(1'b0, 3'b001, 8'd200, 8'd100);
    chk("add_wrap", 8'h2C, 1'b0);
    step(1'b0, 3'b100, 8'd16, 8'd16);
    chk("mul_trunc", 8'h00, 1'b1);
    step(1'b0, 3'b100, 8'd13, 8'd11);
    chk("mul", 8'h8F, 1'b0);

    step(1'b0, 3'b101, 8'h81, 8'd1);
    chk("sll1", 8'h02, 1'b0);
    step(1'b0, 3'b101, 8'h81, 8'd8);
    chk("sll8", 8'h00, 1'b1);
    step(1'b0, 3'b101, 8'h5A, 8'h10);
    chk("sll0_hi_ign", 8'h5A, 1'b0);

    step(1'b0, 3'b110, 8'h80, 8'd3);
    chk("sra3", 8'hF0, 1'b0);
    step(1'b0, 3'b110, 8'h80, 8'd9);
    chk("sra9_neg", 8'hFF, 1'b0);
    step(1'b0, 3'b110, 8'h40, 8'd9);
    chk("sra9_pos", 8'h00, 1'b1);
    step(1'b0, 3'b110, 8'h80, 8'hF0);
    chk("sra0_hi_ign", 8'h80, 1'b0);
    step(1'b0, 3'b110, 8'h7C, 8'd2);
    chk("sra2_pos", 8'h1F, 1'b0);

    step(1'b0, 3'b111, 8'h01, 8'h09);
    chk("ror1", 8'h80, 1'b0);
    step(1'b0, 3'b111, 8'hA5, 8'h08);
    chk("ror0", 8'hA5, 1'b0);
    step(1'b0, 3'b111, 8'h81, 8'd3);
    chk("ror3", 8'h30, 1'b0);

    step(1'b0, 3'b001, 8'd1, 8'd1);
    chk("hold_pre", 8'd2, 1'b0);
    operation = 3'b011;
    data1     = 8'hFF;
    data2     = 8'h00;
    #2;
    chk("hold", 8'd2, 1'b0);

    step(1'b0, 3'b001, 8'd10, 8'd20);
    chk("b2b_add", 8'h1E, 1'b0);
    step(1'b1, 3'b011, 8'h0F, 8'hF0);
    chk("b2b_rst", 8'h00, 1'b1);
    step(1'b0, 3'b010, 8'hFF, 8'h3C);
    chk("b2b_and", 8'h3C, 1'b0);
    step(1'b0, 3'b100, 8'd3, 8'd5);
    chk("b2b_mul", 8'h0F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
